uart_receiver: RTL and testbench

UART receive side, 8N1, LSB-first. Companion to uart_transmitter at the same BAUD and FREQUENCIA_FPGA.
- Synchronizes the asynchronous rx line and detects the start bit.
- Samples each bit at mid-period and emits one byte per frame with a 1-cycle valid pulse.
- Sits between the FPGA pin and the byte-consumer logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_receiver.sv | 146 ++++++++++++++
 tb/tb_uart_receiver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, frame shape and the
// bit-period rounding formula used by both uart_receiver and uart_transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        DATA_BITS = 2'd2,
        STOP      = 2'd3
    } uart_state_t;

    localparam int NUM_DATA_BITS = 8;
    localparam int NUM_STOP_BITS = 1;

    // Rounded to nearest so both ends of the link agree on the same bit period.
    function automatic int clks_per_bit(input int freq_hz, input int baud);
        return (freq_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus a falling-edge
// detector on the synchronized line.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_s_d;

    // NOTE: every flop resets to 1 so the line reads idle and reset release
    // can never look like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let the three stages shift in one
            // edge instead of collapsing into a single flop.
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver, LSB first, mid-bit sampling with a 1-cycle valid pulse.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD            = 115_200,
    parameter int FREQUENCIA_FPGA = 25_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rx,
    output logic [NUM_DATA_BITS-1:0] data,
    output logic                     valid,
    output logic                     framing_error,
    output logic                     active
);

    localparam int CLKS_PER_BIT = clks_per_bit(FREQUENCIA_FPGA, BAUD);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(NUM_DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
    // Vote is taken one cycle after the nominal point; later bit periods keep
    // the same spacing, so only the start threshold moves.
    localparam int START_TICK = HALF;
`else
    localparam int START_TICK = HALF - 1;
`endif

    localparam logic [CNT_W-1:0] START_TICK_C = CNT_W'(START_TICK);
    localparam logic [CNT_W-1:0] BIT_TICK_C   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT_C   = BIT_W'(NUM_DATA_BITS - 1);

    logic rx_s;
    logic fall;
    logic sample_bit;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_h1;
    logic rx_h2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_h1 <= 1'b1;
            rx_h2 <= 1'b1;
        end else begin
            rx_h1 <= rx_s;
            rx_h2 <= rx_h1;
        end
    end

    assign sample_bit = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
    assign sample_bit = rx_s;
`endif

    uart_state_t              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic [NUM_DATA_BITS-1:0] data_d;
    logic                     valid_d, ferr_d, active_d;
    logic                     tick;

    assign tick = (state_q == START) ? (cnt_q == START_TICK_C) : (cnt_q == BIT_TICK_C);

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise
        // paths that skip an assignment infer latches.
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = sample_bit ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {sample_bit, shift_q[NUM_DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT_C) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sample_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            active        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            data          <= data_d;
            valid         <= valid_d;
            framing_error <= ferr_d;
            active        <= active_d;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: framing, back-to-back, glitch, break,
// mid-frame reset and sample-point glitches (majority build when enabled).
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB  = clks_per_bit(25_000_000, 115_200);
    localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    // Cycle of the result pulse relative to the cycle rx was driven low.
    localparam int VOFF = LAT + HALF + (NUM_DATA_BITS + NUM_STOP_BITS) * CPB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       active;

    uart_receiver dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .framing_error (framing_error),
        .active        (active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    int         last_valid_cyc = 0;
    int         last_ferr_cyc = 0;
    logic       active_at_valid = 1'b0;
    logic       active_before_valid = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_active = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt           <= valid_cnt + 1;
            last_valid_cyc      <= cyc;
            active_at_valid     <= active;
            active_before_valid <= prev_active;
            rx_q.push_back(data);
        end
        if (framing_error) begin
            ferr_cnt      <= ferr_cnt + 1;
            last_ferr_cyc <= cyc;
        end
        if (valid && framing_error) both_cnt <= both_cnt + 1;
        if ((valid && prev_valid) || (framing_error && prev_ferr)) wide_cnt <= wide_cnt + 1;
        prev_valid  <= valid;
        prev_ferr   <= framing_error;
        prev_active <= active;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; returns the cycle the start bit began.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic glitch, output int start_cyc);
        logic [9:0] bits;
        bits      = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int j = 0; j < 10; j++) begin
            for (int t = 0; t < CPB; t++) begin
                rx = (glitch && t == HALF) ? ~bits[j] : bits[j];
                @(posedge clk);
                #1;
            end
        end
    endtask

    int n, v0, f0, base;

    initial begin
        rx      = 1'b1;
        reset_n = 1'b0;
        wait_cycles(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", framing_error, 1'b0);
        check("rst_active", active, 1'b0);
        reset_n = 1'b1;
        wait_cycles(20);

        // 1: single 0xA5 frame, exact pulse timing
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, n);
        check("a5_count", valid_cnt - v0, 1);
        check("a5_cycle", last_valid_cyc, n + VOFF);
        check("a5_data", data, 8'hA5);
        check("a5_no_ferr", ferr_cnt, 0);
        check("a5_active_at_valid", active_at_valid, 1'b0);
        check("a5_active_before", active_before_valid, 1'b1);

        // 2: back-to-back frames with no idle gap
        base = rx_q.size();
        send_frame(8'h00, 1'b1, 1'b0, n);
        send_frame(8'hFF, 1'b1, 1'b0, n);
        send_frame(8'h55, 1'b1, 1'b0, n);
        check("b2b_count", rx_q.size() - base, 3);
        if (rx_q.size() - base == 3) begin
            check("b2b_0", rx_q[base], 8'h00);
            check("b2b_1", rx_q[base+1], 8'hFF);
            check("b2b_2", rx_q[base+2], 8'h55);
        end

        // 3: 50-cycle low glitch is rejected at the start sample
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_cycles(10);
        check("glitch_active", active, 1'b1);
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(300);
        check("glitch_idle", active, 1'b0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1, 1'b0, n);
        check("3c_data", data, 8'h3C);
        check("3c_cycle", last_valid_cyc, n + VOFF);

        // 4: stop bit low, then break held for 3000 cycles
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 1'b0, n);
        wait_cycles(3000);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_cycle", last_ferr_cyc, n + VOFF);
        check("ferr_no_valid", valid_cnt - v0, 0);
        check("ferr_data_kept", data, 8'h3C);
        check("break_idle", active, 1'b0);
        rx = 1'b1;
        wait_cycles(50);

        // 5: asynchronous reset during bit 4 of 0x7E
        v0 = valid_cnt;
        fork
            send_frame(8'h7E, 1'b1, 1'b0, n);
            begin
                repeat (5 * CPB + HALF) @(posedge clk);
                #3;
                check("pre_rst_active", active, 1'b1);
                reset_n = 1'b0;
                #1;
                check("mid_rst_active", active, 1'b0);
                check("mid_rst_data", data, 8'h00);
                check("mid_rst_valid", valid, 1'b0);
            end
        join
        wait_cycles(20);
        reset_n = 1'b1;
        wait_cycles(50);
        check("rst_abort_no_valid", valid_cnt - v0, 0);
        check("rst_abort_idle", active, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, n);
        check("12_data", data, 8'h12);
        check("12_count", valid_cnt - v0, 1);

        // 6: one-cycle inversion at every nominal sample point of 0xC3
        v0 = valid_cnt;
        send_frame(8'hC3, 1'b1, 1'b1, n);
`ifdef UART_RX_MAJORITY_EN
        check("c3_count", valid_cnt - v0, 1);
        check("c3_cycle", last_valid_cyc, n + VOFF);
        check("c3_data", data, 8'hC3);
`else
        check("c3_corrupted", data != 8'hC3, 1'b1);
`endif
        wait_cycles(3000);
        check("c3_idle", active, 1'b0);

        check("never_both", both_cnt, 0);
        check("pulse_width", wide_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
